// File: rtl/muldiv_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide unit.
// master: pipeline side (drives start/op/operands and mthi/mtlo writes)
// slave : muldiv_unit (returns busy/done and the HI/LO registers)
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;     // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, x, y, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, x, y, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (aborts any operation)
//   bus   - muldiv_if.slave: start/op/x/y request, hi_we/lo_we/wdata
//           mthi/mtlo writes, busy/done status, hi/lo results
// An accepted start spends 32 edges iterating on operand magnitudes and
// one more edge applying the sign fix-up, so busy is high for 33 cycles.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;    // product, or {remainder, quotient}
  logic [WIDTH-1:0]     r_b;      // multiplicand / divisor magnitude
  logic                 r_mul;
  logic                 r_negq;   // product / quotient must be negated
  logic                 r_negr;   // remainder must be negated (dividend sign)
  logic                 r_dz;     // divide by zero
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done;

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (r_cnt == {CNT_W{1'b1}}) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- operand conditioning (signed ops work on magnitudes) ----
  logic             w_xneg, w_yneg;
  logic [WIDTH-1:0] w_xmag, w_ymag;
  assign w_xneg = ~bus.op[0] & bus.x[WIDTH-1];
  assign w_yneg = ~bus.op[0] & bus.y[WIDTH-1];
  assign w_xmag = w_xneg ? -bus.x : bus.x;
  assign w_ymag = w_yneg ? -bus.y : bus.y;

  // ---- multiply step: add multiplicand on LSB, shift right with carry ----
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mstep;
  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mstep = {w_madd, r_acc[WIDTH-1:1]};

  // ---- restoring divide step: shift in next dividend bit, try subtract ----
  // Shifted remainder needs WIDTH+1 bits; its top bit set means the
  // subtract always succeeds.
  logic [WIDTH:0]     w_rsh, w_diff;
  logic [2*WIDTH-1:0] w_dstep;
  assign w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_rsh - {1'b0, r_b};
  assign w_dstep = w_diff[WIDTH] ? {w_rsh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // ---- sign fix-up ----
  // With a zero divisor every subtract succeeds: quotient magnitude is all
  // ones and the remainder equals |x|, which the dividend-sign fix-up turns
  // back into x. Only the quotient needs overriding.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_quo  = r_dz ? '1 : (r_negq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_negr ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_mul  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (bus.start) begin
            r_cnt  <= '0;
            r_mul  <= ~bus.op[1];
            r_acc  <= {{WIDTH{1'b0}}, w_xmag};
            r_b    <= w_ymag;
            r_negq <= w_xneg ^ w_yneg;
            r_negr <= w_xneg;
            r_dz   <= bus.op[1] & (bus.y == '0);
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_mul ? w_mstep : w_dstep;
        end
        S_FIN: begin
          if (r_mul) {r_hi, r_lo} <= w_prod;
          else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
